// File: rtl/matrix_pkg.sv
// Shared definitions for the note-bitmap display path.
// Holds the scan FSM state encoding, the bitmap geometry constants and the
// R/G/B bit positions inside a 3-bit pixel, which the renderer uses as well.
// No ports.
package matrix_pkg;

    localparam int PIXEL_BITS = 3;
    localparam int BITMAP_W   = 210;   // 70 px x 3-bit RGB
    localparam int R_BIT      = 2;
    localparam int G_BIT      = 1;
    localparam int B_BIT      = 0;
    localparam int ADDR_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_t;

    // Bits needed to index n items, never less than one.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_row_shifter.sv
// Row word shifter for the panel scan.
// Holds one 3*COLS-bit row; the highest pixel sits at the top of the word and
// is what the panel data pins show. Each column step shifts the word left by
// one pixel, so pixels leave highest column first and column 0 leaves last.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears the word)
//   load        - capture row_word (start of a row)
//   shift       - move the next lower pixel to the top
//   row_word    - row contents, pixel c at bits [3c+2:3c]
//   pixel       - current top pixel {R,G,B}, straight from the register
module matrix_row_shifter
    import matrix_pkg::*;
#(
    parameter int COLS = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       shift,
    input  logic [PIXEL_BITS*COLS-1:0] row_word,
    output logic [PIXEL_BITS-1:0]      pixel
);

    localparam int WORD_W = PIXEL_BITS * COLS;

    logic [WORD_W-1:0] word_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg <= '0;
        end else if (load) begin
            word_reg <= row_word;
        end else if (shift) begin
            word_reg <= word_reg << PIXEL_BITS;
        end
    end

    assign pixel = word_reg[WORD_W-1 -: PIXEL_BITS];

endmodule

// File: rtl/matrix_scan_out.sv
// HUB75-style scan-out of the seven note-renderer row bitmaps.
// Each frame snapshots every row, then per row shifts COLS pixels out
// (highest column first), blanks, latches with the row address and lights
// the row for DISPLAY_CYCLES clocks. All outputs come from flops.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   enable              - start/continue frames (looked at in IDLE and frame end)
//   bitmap0..bitmap6    - row bitmaps, pixel c = bits [3c+2:3c] = {R,G,B}
//   panel_r/g/b         - serial pixel data
//   panel_clk           - panel shift clock
//   panel_lat           - latch strobe, active high
//   panel_oe_n          - output enable, active low
//   panel_addr          - row address (ROW_BASE + row, 4-bit wrap)
//   busy                - high from snapshot until the frame finishes
//   frame_done          - one-cycle pulse after the last row's display time
// ROWS must not exceed the seven bitmap ports; COLS must not exceed 70.
module matrix_scan_out
    import matrix_pkg::*;
#(
    parameter int COLS           = 64,
    parameter int ROWS           = 7,
    parameter int DISPLAY_CYCLES = 256,
    parameter int ROW_BASE       = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [BITMAP_W-1:0] bitmap0,
    input  logic [BITMAP_W-1:0] bitmap1,
    input  logic [BITMAP_W-1:0] bitmap2,
    input  logic [BITMAP_W-1:0] bitmap3,
    input  logic [BITMAP_W-1:0] bitmap4,
    input  logic [BITMAP_W-1:0] bitmap5,
    input  logic [BITMAP_W-1:0] bitmap6,
    output logic                panel_r,
    output logic                panel_g,
    output logic                panel_b,
    output logic                panel_clk,
    output logic                panel_lat,
    output logic                panel_oe_n,
    output logic [ADDR_W-1:0]   panel_addr,
    output logic                busy,
    output logic                frame_done
);

    localparam int WORD_W = PIXEL_BITS * COLS;
    localparam int COL_W  = index_width(COLS);
    localparam int ROW_W  = index_width(ROWS);
    localparam int DISP_W = $clog2(DISPLAY_CYCLES + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [DISP_W-1:0] DISP_LOAD = DISP_W'(DISPLAY_CYCLES);
    localparam logic [DISP_W-1:0] DISP_ONE  = DISP_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(ROW_BASE);

    // Visible part of each bitmap port
    logic [WORD_W-1:0] bitmap_word [7];

    assign bitmap_word[0] = bitmap0[WORD_W-1:0];
    assign bitmap_word[1] = bitmap1[WORD_W-1:0];
    assign bitmap_word[2] = bitmap2[WORD_W-1:0];
    assign bitmap_word[3] = bitmap3[WORD_W-1:0];
    assign bitmap_word[4] = bitmap4[WORD_W-1:0];
    assign bitmap_word[5] = bitmap5[WORD_W-1:0];
    assign bitmap_word[6] = bitmap6[WORD_W-1:0];

    // Columns beyond COLS are never shown
    if (WORD_W < BITMAP_W) begin : g_unused
        logic unused_bits;
        assign unused_bits = ^{bitmap0[BITMAP_W-1:WORD_W], bitmap1[BITMAP_W-1:WORD_W],
                               bitmap2[BITMAP_W-1:WORD_W], bitmap3[BITMAP_W-1:WORD_W],
                               bitmap4[BITMAP_W-1:WORD_W], bitmap5[BITMAP_W-1:WORD_W],
                               bitmap6[BITMAP_W-1:WORD_W]};
    end

    scan_state_t       state_reg, state_next;
    logic [ROW_W-1:0]  row_reg, row_next;
    logic [COL_W-1:0]  col_reg, col_next;
    logic [DISP_W-1:0] disp_cnt_reg, disp_cnt_next;

    logic              busy_next;
    logic              frame_done_next;
    logic              panel_clk_next;
    logic              panel_lat_next;
    logic              panel_oe_n_next;
    logic [ADDR_W-1:0] panel_addr_next;

    logic              start_frame;
    logic              snap_load;
    logic              row_load;
    logic              row_shift;
    logic              row_from_input;
    logic [WORD_W-1:0] row_word;
    logic [PIXEL_BITS-1:0] pixel;

    // Frame snapshot: the inputs are only looked at on the snapshot edge, so
    // the renderer may update freely while a frame is being scanned.
    logic [WORD_W-1:0] snap_rows [ROWS];

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_snap
        logic [WORD_W-1:0] word_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_reg <= '0;
            end else if (snap_load) begin
                word_reg <= bitmap_word[gi];
            end
        end

        assign snap_rows[gi] = word_reg;
    end

    // Row 0 of a new frame is loaded on the same edge as the snapshot, so it
    // has to come straight from the input port rather than the snapshot.
    assign row_word = row_from_input ? bitmap_word[0] : snap_rows[row_next];

    matrix_row_shifter #(
        .COLS (COLS)
    ) u_row_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (row_load),
        .shift    (row_shift),
        .row_word (row_word),
        .pixel    (pixel)
    );

    assign panel_r = pixel[R_BIT];
    assign panel_g = pixel[G_BIT];
    assign panel_b = pixel[B_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            row_reg      <= '0;
            col_reg      <= '0;
            disp_cnt_reg <= '0;
            panel_clk    <= 1'b0;
            panel_lat    <= 1'b0;
            panel_oe_n   <= 1'b1;
            panel_addr   <= ADDR_BASE;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            disp_cnt_reg <= disp_cnt_next;
            panel_clk    <= panel_clk_next;
            panel_lat    <= panel_lat_next;
            panel_oe_n   <= panel_oe_n_next;
            panel_addr   <= panel_addr_next;
            busy         <= busy_next;
            frame_done   <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        disp_cnt_next   = disp_cnt_reg;
        busy_next       = busy;
        frame_done_next = 1'b0;
        start_frame     = 1'b0;
        snap_load       = 1'b0;
        row_load        = 1'b0;
        row_shift       = 1'b0;
        row_from_input  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    start_frame = 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                state_next = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (col_reg == '0) begin
                    state_next = ST_BLANK;
                end else begin
                    col_next   = col_reg - 1'b1;
                    row_shift  = 1'b1;
                    state_next = ST_SHIFT_LO;
                end
            end
            ST_BLANK: begin
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                disp_cnt_next = DISP_LOAD;
                state_next    = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (disp_cnt_reg > DISP_ONE) begin
                    disp_cnt_next = disp_cnt_reg - 1'b1;
                end else if (row_reg != ROW_LAST) begin
                    row_next   = row_reg + 1'b1;
                    col_next   = COL_LAST;
                    row_load   = 1'b1;
                    state_next = ST_SHIFT_LO;
                end else begin
                    frame_done_next = 1'b1;
                    if (enable) begin
                        start_frame = 1'b1;
                    end else begin
                        busy_next  = 1'b0;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Same entry into a frame from IDLE and from back-to-back frame end
        if (start_frame) begin
            snap_load      = 1'b1;
            row_from_input = 1'b1;
            row_load       = 1'b1;
            row_next       = '0;
            col_next       = COL_LAST;
            busy_next      = 1'b1;
            state_next     = ST_SHIFT_LO;
        end

        // Panel controls are registered versions of the state being entered
        panel_clk_next  = (state_next == ST_SHIFT_HI);
        panel_lat_next  = (state_next == ST_LATCH);
        panel_oe_n_next = (state_next != ST_DISPLAY);
        panel_addr_next = (state_next == ST_LATCH) ? ADDR_BASE + ADDR_W'(row_reg) : panel_addr;
    end

endmodule

// File: tb/tb_matrix_scan_out.sv
// Bench for matrix_scan_out: COLS=64, DISPLAY_CYCLES=4, with a second copy at
// ROW_BASE=8. A frame-level reference model tracks snapshot contents and frame
// timing from plain arithmetic; a monitor rebuilds each shifted row from the
// panel pins and compares it with the model's snapshot.
module tb_matrix_scan_out;

    localparam int COLS       = 64;
    localparam int ROWS       = 7;
    localparam int DC         = 4;
    localparam int ROW_PERIOD = 2 * COLS + 2 + DC;
    localparam int FRAME      = ROWS * ROW_PERIOD;
    localparam int WW         = 3 * COLS;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         enable = 1'b0;
    logic [209:0] bm [7];

    logic       panel_r, panel_g, panel_b, panel_clk, panel_lat, panel_oe_n, busy, frame_done;
    logic [3:0] panel_addr;
    logic       b_r, b_g, b_b, b_clk, b_lat, b_oe_n, b_busy, b_done;
    logic [3:0] b_addr;

    always #5 clk = ~clk;

    matrix_scan_out #(.COLS(COLS), .ROWS(ROWS), .DISPLAY_CYCLES(DC), .ROW_BASE(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .bitmap0(bm[0]), .bitmap1(bm[1]), .bitmap2(bm[2]), .bitmap3(bm[3]),
        .bitmap4(bm[4]), .bitmap5(bm[5]), .bitmap6(bm[6]),
        .panel_r(panel_r), .panel_g(panel_g), .panel_b(panel_b),
        .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
        .panel_addr(panel_addr), .busy(busy), .frame_done(frame_done)
    );

    matrix_scan_out #(.COLS(COLS), .ROWS(ROWS), .DISPLAY_CYCLES(DC), .ROW_BASE(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .bitmap0(bm[0]), .bitmap1(bm[1]), .bitmap2(bm[2]), .bitmap3(bm[3]),
        .bitmap4(bm[4]), .bitmap5(bm[5]), .bitmap6(bm[6]),
        .panel_r(b_r), .panel_g(b_g), .panel_b(b_b),
        .panel_clk(b_clk), .panel_lat(b_lat), .panel_oe_n(b_oe_n),
        .panel_addr(b_addr), .busy(b_busy), .frame_done(b_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [209:0] rnd210();
        logic [223:0] t;
        for (int k = 0; k < 7; k++) t[32*k +: 32] = $urandom;
        return t[209:0];
    endfunction

    // ---------------- frame-level reference model ----------------
    logic          m_active = 1'b0;
    logic          m_done   = 1'b0;
    int            m_left   = 0;
    logic [WW-1:0] m_snap [ROWS];

    task automatic model_snapshot();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_snap[r][3*c +: 3] = bm[r][3*c +: 3];
        m_active = 1'b1;
        m_left   = FRAME;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0;
                m_done   = 1'b0;
                m_left   = 0;
            end else begin
                m_done = 1'b0;
                if (m_active) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        if (enable) model_snapshot();
                        else m_active = 1'b0;
                    end
                end else if (enable) begin
                    model_snapshot();
                end
            end
        end
    end

    // ---------------- pin monitor ----------------
    logic          mon_pclk = 1'b0;
    logic          mon_plat = 1'b0;
    int            mon_si   = 0;
    int            mon_lats = 0;
    int            mon_rise = 0;
    int            mon_oe   = 0;
    logic [WW-1:0] mon_cap  = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_pclk = 1'b0; mon_plat = 1'b0;
                mon_si = 0; mon_lats = 0; mon_rise = 0; mon_oe = 0;
                mon_cap = '0;
            end else begin
                check("busy", busy, m_active);
                check("frame_done", frame_done, m_done);
                if (panel_clk && !mon_pclk) begin
                    if (mon_si < COLS) mon_cap[3*(COLS-1-mon_si) +: 3] = {panel_r, panel_g, panel_b};
                    mon_si++;
                    mon_rise++;
                end
                if (panel_lat) begin
                    check("lat_while_oe", panel_oe_n, 1'b1);
                    if (!mon_plat && mon_lats < ROWS) begin
                        check("row_shift_count", mon_si, COLS);
                        check("row_data", mon_cap, m_snap[mon_lats]);
                        check("addr", panel_addr, mon_lats);
                        check("addr_base8", {b_lat, b_addr}, {1'b1, 4'(8 + mon_lats)});
                        mon_si  = 0;
                        mon_cap = '0;
                        mon_lats++;
                    end
                end
                if (!panel_oe_n) begin
                    check("clk_in_display", panel_clk, 1'b0);
                    mon_oe++;
                end else if (mon_oe != 0) begin
                    check("oe_low_len", mon_oe, DC);
                    mon_oe = 0;
                end
                if (frame_done) begin
                    check("frame_clk_rises", mon_rise, ROWS * COLS);
                    check("frame_lat_pulses", mon_lats, ROWS);
                    mon_rise = 0;
                    mon_lats = 0;
                end
                mon_pclk = panel_clk;
                mon_plat = panel_lat;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < FRAME + 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, frame_done, 1'b1);
        @(negedge clk);
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 7; r++) bm[r] = '0;
        repeat (3) @(negedge clk);
        check("rst_rgb", {panel_r, panel_g, panel_b}, 3'b000);
        check("rst_clk", panel_clk, 1'b0);
        check("rst_lat", panel_lat, 1'b0);
        check("rst_oe_n", panel_oe_n, 1'b1);
        check("rst_addr", panel_addr, 4'd0);
        check("rst_addr_base8", b_addr, 4'd8);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        rst_n = 1'b1;

        // all-zero frame from a single-cycle enable
        pulse_enable();
        wait_done("zero_frame");
        repeat (3) @(negedge clk);
        check("zero_idle_busy", busy, 1'b0);
        check("zero_idle_oe_n", panel_oe_n, 1'b1);

        // red note at pixel 0 and 011 at pixel 63 of row 2
        bm[2][2:0]   = 3'b100;
        bm[2][189 +: 3] = 3'b011;
        pulse_enable();
        wait_done("note_frame");

        // snapshot integrity: row 3 changes while row 0 is shifting
        for (int r = 0; r < 7; r++) bm[r] = rnd210();
        bm[3] = '1;
        @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        for (int r = 0; r < 7; r++) bm[r] = rnd210();
        bm[3] = '0;
        wait_done("snap_frame1");
        repeat (400) @(negedge clk);
        enable = 1'b0;
        wait_done("snap_frame2");
        repeat (3) @(negedge clk);
        check("stop_idle_busy", busy, 1'b0);

        // asynchronous reset in the middle of row 3's display time
        for (int r = 0; r < 7; r++) bm[r] = rnd210();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (3 * ROW_PERIOD + 2 * COLS + 3) @(negedge clk);
        check("pre_rst_oe_n", panel_oe_n, 1'b0);
        check("pre_rst_addr", panel_addr, 4'd3);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_oe_n", panel_oe_n, 1'b1);
        check("midrst_lat", panel_lat, 1'b0);
        check("midrst_clk", panel_clk, 1'b0);
        check("midrst_addr", panel_addr, 4'd0);
        check("midrst_addr_base8", b_addr, 4'd8);
        check("midrst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_oe_n", panel_oe_n, 1'b1);
        check("post_rst_clk", panel_clk, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
